// File: rtl/eyeriss_pkg.sv
// ---------------------------------------------------------------------------
// eyeriss_pkg
//
// Shared definitions for the global-buffer to multicast-router path.
//   - Default bus widths used by both the tag sequencer and the
//     MulticastRouter, so the two always agree on value and tag widths.
//   - seq_state_t: the burst sequencer state encoding.
// ---------------------------------------------------------------------------
package eyeriss_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ID_WIDTH   = 8;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_LEN_WIDTH  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/multicast_tag_sequencer.sv
// ---------------------------------------------------------------------------
// multicast_tag_sequencer
//
// Takes a burst command, streams cmd_len consecutive words out of a
// global-buffer SRAM (1-cycle read latency), tags each word with a
// destination ID and presents it to the multicast router. The router cannot
// push back, so stall_i pauses issue and emission; a single hold register
// catches the one word that can still be in flight when a stall begins.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake (ready only while IDLE)
//   cmd_base_addr_i       SRAM address of the first word
//   cmd_len_i             number of words (0 is legal: done only)
//   cmd_tag_base_i        tag of the first word
//   cmd_tag_period_i      words per tag value (0 keeps the tag constant)
//   stall_i               suppress reads and emission this cycle
//   mem_rd_en_o/addr_o    SRAM read strobe and address
//   mem_rd_data_i         SRAM data, valid the cycle after mem_rd_en_o
//   out_val_o/tag_id_o    word and tag to the router
//   out_valid_o           router in_valid
//   done_o                one-cycle pulse with the last word of a burst
// ---------------------------------------------------------------------------
module multicast_tag_sequencer
    import eyeriss_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ID_WIDTH   = DEFAULT_ID_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [ID_WIDTH-1:0]   cmd_tag_base_i,
    input  logic [ID_WIDTH-1:0]   cmd_tag_period_i,
    input  logic                  stall_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] out_val_o,
    output logic [ID_WIDTH-1:0]   out_tag_id_o,
    output logic                  out_valid_o,
    output logic                  done_o
);

    seq_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] baseAddr_q, baseAddr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issueCnt_q, issueCnt_d;
    logic [LEN_WIDTH-1:0]  emitCnt_q, emitCnt_d;
    logic [ID_WIDTH-1:0]   tagPeriod_q, tagPeriod_d;
    logic [ID_WIDTH-1:0]   subCnt_q, subCnt_d;
    logic [ID_WIDTH-1:0]   curTag_q, curTag_d;
    logic                  rdPending_q, rdPending_d;
    logic                  holdFull_q, holdFull_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] outVal_q, outVal_d;
    logic [ID_WIDTH-1:0]   outTag_q, outTag_d;
    logic                  outValid_q, outValid_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  issue;
    logic                  emitNow;
    logic                  lastWord;
    logic [DATA_WIDTH-1:0] emitData;

    // Burst control. A command is only taken in IDLE; a zero-length burst
    // never leaves IDLE and just produces the done pulse. RUN issues one read
    // per unstalled cycle and moves to DRAIN right after the final issue.
    // DRAIN waits for the done pulse that rides with the last emitted word,
    // so cmd_ready comes back the cycle after done.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept = 1'b1;
                    if (cmd_len_i != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!stall_i) begin
                    issue = 1'b1;
                    if (issueCnt_q + LEN_WIDTH'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A word is ready to go out when read data returns or the hold register
    // is occupied. Both never happen together: the hold register fills only
    // during a stall, and a stall also blocks the read whose data would have
    // returned in the first unstalled cycle afterwards.
    assign emitNow  = !stall_i && (holdFull_q || rdPending_q);
    assign emitData = holdFull_q ? hold_q : mem_rd_data_i;
    assign lastWord = (emitCnt_q == len_q - LEN_WIDTH'(1));

    // Datapath next-state. The tag advances on emission rather than issue so
    // the tag sequence follows output order even across stalls. The command
    // latch is evaluated last so a fresh burst always starts from clean
    // counters and the new tag base.
    always_comb begin
        baseAddr_d  = baseAddr_q;
        len_d       = len_q;
        tagPeriod_d = tagPeriod_q;
        issueCnt_d  = issueCnt_q;
        emitCnt_d   = emitCnt_q;
        subCnt_d    = subCnt_q;
        curTag_d    = curTag_q;
        holdFull_d  = holdFull_q;
        hold_d      = hold_q;
        outVal_d    = outVal_q;
        outTag_d    = outTag_q;
        rdPending_d = issue;
        outValid_d  = emitNow;
        done_d      = (accept && (cmd_len_i == '0)) || (emitNow && lastWord);

        if (issue) begin
            issueCnt_d = issueCnt_q + LEN_WIDTH'(1);
        end

        if (stall_i && rdPending_q) begin
            hold_d     = mem_rd_data_i;
            holdFull_d = 1'b1;
        end else if (emitNow && holdFull_q) begin
            holdFull_d = 1'b0;
        end

        if (emitNow) begin
            outVal_d  = emitData;
            outTag_d  = curTag_q;
            emitCnt_d = emitCnt_q + LEN_WIDTH'(1);
            if (tagPeriod_q != '0) begin
                if (subCnt_q == tagPeriod_q - ID_WIDTH'(1)) begin
                    subCnt_d = '0;
                    curTag_d = curTag_q + ID_WIDTH'(1);
                end else begin
                    subCnt_d = subCnt_q + ID_WIDTH'(1);
                end
            end
        end

        if (accept) begin
            baseAddr_d  = cmd_base_addr_i;
            len_d       = cmd_len_i;
            tagPeriod_d = cmd_tag_period_i;
            issueCnt_d  = '0;
            emitCnt_d   = '0;
            subCnt_d    = '0;
            curTag_d    = cmd_tag_base_i;
        end
    end

    // State register. Reset also clears rdPending_q, which is what drops any
    // read still in flight when reset lands mid-burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            baseAddr_q  <= '0;
            len_q       <= '0;
            tagPeriod_q <= '0;
            issueCnt_q  <= '0;
            emitCnt_q   <= '0;
            subCnt_q    <= '0;
            curTag_q    <= '0;
            rdPending_q <= 1'b0;
            holdFull_q  <= 1'b0;
            hold_q      <= '0;
            outVal_q    <= '0;
            outTag_q    <= '0;
            outValid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baseAddr_q  <= baseAddr_d;
            len_q       <= len_d;
            tagPeriod_q <= tagPeriod_d;
            issueCnt_q  <= issueCnt_d;
            emitCnt_q   <= emitCnt_d;
            subCnt_q    <= subCnt_d;
            curTag_q    <= curTag_d;
            rdPending_q <= rdPending_d;
            holdFull_q  <= holdFull_d;
            hold_q      <= hold_d;
            outVal_q    <= outVal_d;
            outTag_q    <= outTag_d;
            outValid_q  <= outValid_d;
            done_q      <= done_d;
        end
    end

    // The read address wraps naturally at the SRAM address width.
    assign cmd_ready_o   = (state_q == IDLE);
    assign mem_rd_en_o   = issue;
    assign mem_rd_addr_o = baseAddr_q + ADDR_WIDTH'(issueCnt_q);
    assign out_val_o     = outVal_q;
    assign out_tag_id_o  = outTag_q;
    assign out_valid_o   = outValid_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_multicast_tag_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicast_tag_sequencer
//
// Bench for the multicast tag sequencer. A behavioural SRAM with one cycle
// of read latency holds mem[a] = a. Each command pushes the words it should
// produce (value, tag, last-word flag) onto a scoreboard queue, and every
// out_valid cycle pops and compares against the head of that queue.
// ---------------------------------------------------------------------------
module tb_multicast_tag_sequencer;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int AW = 10;
    localparam int LW = 10;

    typedef struct packed {
        logic [DW-1:0] val;
        logic [IW-1:0] tag;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_addr;
    logic [LW-1:0] cmd_len;
    logic [IW-1:0] cmd_tag_base;
    logic [IW-1:0] cmd_tag_period;
    logic          stall;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] out_val;
    logic [IW-1:0] out_tag_id;
    logic          out_valid;
    logic          done;

    logic [DW-1:0] mem [1024];
    exp_t          sb[$];
    int            compared   = 0;
    int            mismatched = 0;

    multicast_tag_sequencer #(
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_base_addr_i (cmd_base_addr),
        .cmd_len_i       (cmd_len),
        .cmd_tag_base_i  (cmd_tag_base),
        .cmd_tag_period_i(cmd_tag_period),
        .stall_i         (stall),
        .mem_rd_en_o     (mem_rd_en),
        .mem_rd_addr_o   (mem_rd_addr),
        .mem_rd_data_i   (mem_rd_data),
        .out_val_o       (out_val),
        .out_tag_id_o    (out_tag_id),
        .out_valid_o     (out_valid),
        .done_o          (done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Global-buffer SRAM model: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
        end
    end

    // Scoreboard model: word k comes from base+k (address wraps) and carries
    // tag_base + floor(k/period) (tag wraps), or tag_base when period is 0.
    task automatic pushExpected(input logic [AW-1:0] base, input logic [LW-1:0] len,
                                input logic [IW-1:0] tagb, input logic [IW-1:0] period);
        exp_t          e;
        logic [AW-1:0] a;
        for (int k = 0; k < int'(len); k++) begin
            a      = base + AW'(k);
            e.val  = mem[a];
            e.tag  = (period == '0) ? tagb : tagb + IW'(k / int'(period));
            e.last = (k == int'(len) - 1);
            sb.push_back(e);
        end
    endtask

    // Offer one command for a single cycle (caller is at a negedge in IDLE).
    // Returns at the negedge of the cycle after the handshake (T+1).
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] len,
                                 input logic [IW-1:0] tagb, input logic [IW-1:0] period);
        cmd_base_addr  = base;
        cmd_len        = len;
        cmd_tag_base   = tagb;
        cmd_tag_period = period;
        cmd_valid      = 1'b1;
        pushExpected(base, len, tagb, period);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_base_addr  = '0;
        cmd_len        = '0;
        cmd_tag_base   = '0;
        cmd_tag_period = '0;
        stall          = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++; if (out_val !== '0) begin mismatched++; $display("[TB] FAIL reset_out_val: got %h expected 0", out_val); end
        compared++; if (out_tag_id !== '0) begin mismatched++; $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag_id); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        compared++; if (mem_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_basic_burst();
        exp_t e;
        int   cyc = 1;
        int   k   = 0;
        applyStimulus(10'h010, 10'd4, 8'd3, 8'd2);
        compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_busy_ready: got %b expected 0", cmd_ready); end
        compared++; if (mem_rd_en !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_first_rd: got %b expected 1", mem_rd_en); end
        compared++; if (mem_rd_addr !== 10'h010) begin mismatched++; $display("[TB] FAIL basic_first_addr: got %h expected 010", mem_rd_addr); end
        while (sb.size() > 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                e = sb.pop_front();
                compared++; if (out_val !== e.val) begin mismatched++; $display("[TB] FAIL basic_val: got %h expected %h", out_val, e.val); end
                compared++; if (out_tag_id !== e.tag) begin mismatched++; $display("[TB] FAIL basic_tag: got %h expected %h", out_tag_id, e.tag); end
                compared++; if (done !== e.last) begin mismatched++; $display("[TB] FAIL basic_done: got %b expected %b", done, e.last); end
                compared++; if (cyc !== 3 + k) begin mismatched++; $display("[TB] FAIL basic_latency: got cycle %0d expected %0d", cyc, 3 + k); end
                k++;
            end else begin
                compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_stray_done: got %b expected 0", done); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL basic_timeout: got %0d words pending expected 0", sb.size()); end
        sb.delete();
        @(negedge clk);
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_ready_after_done: got %b expected 1", cmd_ready); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_width: got %b expected 0", done); end
    endtask

    task automatic test_len_zero();
        applyStimulus(10'h100, 10'd0, 8'd5, 8'd1);
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_done: got %b expected 1", done); end
        compared++; if (mem_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL len0_rd_en_t1: got %b expected 0", mem_rd_en); end
        @(negedge clk);
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL len0_done_t2: got %b expected 0", done); end
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_ready_t2: got %b expected 1", cmd_ready); end
        compared++; if (mem_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL len0_rd_en_t2: got %b expected 0", mem_rd_en); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL len0_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_stall();
        exp_t e;
        int   cyc     = 1;
        int   seen    = 0;
        int   bubbles = 0;
        applyStimulus(10'h040, 10'd6, 8'h10, 8'd3);
        while (sb.size() > 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                e = sb.pop_front();
                compared++; if (out_val !== e.val) begin mismatched++; $display("[TB] FAIL stall_val: got %h expected %h", out_val, e.val); end
                compared++; if (out_tag_id !== e.tag) begin mismatched++; $display("[TB] FAIL stall_tag: got %h expected %h", out_tag_id, e.tag); end
                compared++; if (done !== e.last) begin mismatched++; $display("[TB] FAIL stall_done: got %b expected %b", done, e.last); end
                seen++;
            end else if (seen > 0) begin
                bubbles++;
            end
            if (cyc == 4) begin
                compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_forced_bubble: got %b expected 0", out_valid); end
            end
            stall = (cyc == 3);
            if (stall) begin
                #1;
                compared++; if (mem_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_rd_gated: got %b expected 0", mem_rd_en); end
            end
        end
        stall = 1'b0;
        compared++; if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL stall_timeout: got %0d words pending expected 0", sb.size()); end
        compared++; if (bubbles != 1) begin mismatched++; $display("[TB] FAIL stall_bubbles: got %0d expected 1", bubbles); end
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        exp_t          e;
        logic [AW-1:0] ea;
        int            issued = 0;
        applyStimulus(10'h3FE, 10'd4, 8'hFF, 8'd1);
        for (int c = 1; c < 20 && sb.size() > 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_rd_en) begin
                ea = 10'h3FE + AW'(issued);
                compared++; if (mem_rd_addr !== ea) begin mismatched++; $display("[TB] FAIL wrap_addr: got %h expected %h", mem_rd_addr, ea); end
                issued++;
            end
            if (out_valid) begin
                e = sb.pop_front();
                compared++; if (out_val !== e.val) begin mismatched++; $display("[TB] FAIL wrap_val: got %h expected %h", out_val, e.val); end
                compared++; if (out_tag_id !== e.tag) begin mismatched++; $display("[TB] FAIL wrap_tag: got %h expected %h", out_tag_id, e.tag); end
                compared++; if (done !== e.last) begin mismatched++; $display("[TB] FAIL wrap_done: got %b expected %b", done, e.last); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL wrap_timeout: got %0d words pending expected 0", sb.size()); end
        compared++; if (issued != 4) begin mismatched++; $display("[TB] FAIL wrap_issue_count: got %0d expected 4", issued); end
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        int   emitted = 0;
        applyStimulus(10'h200, 10'd8, 8'd1, 8'd0);
        for (int c = 0; c < 20 && emitted < 2; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = sb.pop_front();
                compared++; if (out_val !== e.val) begin mismatched++; $display("[TB] FAIL rstmid_val: got %h expected %h", out_val, e.val); end
                emitted++;
            end
        end
        compared++; if (emitted != 2) begin mismatched++; $display("[TB] FAIL rstmid_pre_words: got %0d expected 2", emitted); end
        rst = 1'b1;
        @(negedge clk);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        compared++; if (out_val !== '0) begin mismatched++; $display("[TB] FAIL rstmid_out_val: got %h expected 0", out_val); end
        compared++; if (out_tag_id !== '0) begin mismatched++; $display("[TB] FAIL rstmid_out_tag: got %h expected 0", out_tag_id); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_done: got %b expected 0", done); end
        compared++; if (mem_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_rd_en: got %b expected 0", mem_rd_en); end
        compared++; if (mem_rd_addr !== '0) begin mismatched++; $display("[TB] FAIL rstmid_rd_addr: got %h expected 0", mem_rd_addr); end
        compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_cmd_ready: got %b expected 1", cmd_ready); end
        rst = 1'b0;
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_discard: got %b expected 0", out_valid); end
            compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_no_done: got %b expected 0", done); end
        end
        applyStimulus(10'h300, 10'd3, 8'd7, 8'd0);
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = sb.pop_front();
                compared++; if (out_val !== e.val) begin mismatched++; $display("[TB] FAIL rstmid_new_val: got %h expected %h", out_val, e.val); end
                compared++; if (out_tag_id !== e.tag) begin mismatched++; $display("[TB] FAIL rstmid_new_tag: got %h expected %h", out_tag_id, e.tag); end
                compared++; if (done !== e.last) begin mismatched++; $display("[TB] FAIL rstmid_new_done: got %b expected %b", done, e.last); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL rstmid_new_timeout: got %0d words pending expected 0", sb.size()); end
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   accepts  = 0;
        int   dones    = 0;
        int   lastDone = -100;
        cmd_base_addr  = 10'h080;
        cmd_len        = 10'd3;
        cmd_tag_base   = 8'h20;
        cmd_tag_period = 8'd2;
        cmd_valid      = 1'b1;
        for (int c = 0; c < 200 && (accepts < 3 || sb.size() > 0); c++) begin
            if (c > 0) @(negedge clk);
            if (accepts == 3) cmd_valid = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL b2b_extra_word: got value %h expected no word", out_val);
                end else begin
                    e = sb.pop_front();
                    compared++; if (out_val !== e.val) begin mismatched++; $display("[TB] FAIL b2b_val: got %h expected %h", out_val, e.val); end
                    compared++; if (out_tag_id !== e.tag) begin mismatched++; $display("[TB] FAIL b2b_tag: got %h expected %h", out_tag_id, e.tag); end
                    compared++; if (done !== e.last) begin mismatched++; $display("[TB] FAIL b2b_done: got %b expected %b", done, e.last); end
                end
            end else begin
                compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_stray_done: got %b expected 0", done); end
            end
            if (done) begin
                dones++;
                lastDone = c;
            end
            if (cmd_valid && cmd_ready) begin
                if (accepts > 0) begin
                    compared++; if (c != lastDone + 1) begin mismatched++; $display("[TB] FAIL b2b_accept_gap: got cycle %0d expected %0d", c, lastDone + 1); end
                end
                pushExpected(cmd_base_addr, cmd_len, cmd_tag_base, cmd_tag_period);
                accepts++;
            end
        end
        cmd_valid = 1'b0;
        compared++; if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL b2b_timeout: got %0d words pending expected 0", sb.size()); end
        compared++; if (dones != 3) begin mismatched++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", dones); end
        sb.delete();
    endtask

    // Scenario sequence.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        mem_rd_data = '0;
        test_reset();
        test_basic_burst();
        test_len_zero();
        test_stall();
        test_wrap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicast_tag_sequencer.md
# multicast_tag_sequencer

Upstream feeder for the multicast router. Accepts a burst command and reads `len` consecutive words from a global-buffer SRAM port (1-cycle read latency). It tags each word with a destination ID and drives the router's value/tag/valid inputs. The router has no backpressure, so a `stall` input (aggregated PE-FIFO-full) pauses issue; in-flight data is held in a one-entry skid register so nothing is lost or reordered.

## Interface
- `DATA_WIDTH`, 16, word width; matches router `in_val`
- `ID_WIDTH`, 8, tag width; matches router `tag_id`
- `ADDR_WIDTH`, 10, SRAM address width
- `LEN_WIDTH`, 10, burst length field width
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_base_addr`  in  ADDR_WIDTH  first SRAM address
- `cmd_len`  in  LEN_WIDTH  word count; 0 legal
- `cmd_tag_base`  in  ID_WIDTH  tag of first word
- `cmd_tag_period`  in  ID_WIDTH  words per tag; 0 = constant tag
- `stall`  in  1  suppress issue and emission
- `mem_rd_en`  out  1  SRAM read strobe
- `mem_rd_addr`  out  ADDR_WIDTH  SRAM read address
- `mem_rd_data`  in  DATA_WIDTH  valid the cycle after `mem_rd_en`
- `out_val`  out  DATA_WIDTH  to router `in_val`
- `out_tag_id`  out  ID_WIDTH  to router `tag_id`
- `out_valid`  out  1  to router `in_valid`
- `done`  out  1  one-cycle pulse, burst complete

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all cmd fields and clear the issue and emit counters.
  - If len≠0, go to RUN. If len=0, pulse `done` next cycle and stay in IDLE.
- RUN:
  - Each cycle with `stall`=0, `mem_rd_en`=1 and `mem_rd_addr`=base+issue_cnt (mod 2^ADDR_WIDTH); then issue_cnt++.
  - `mem_rd_en` is combinationally gated by `stall`.
  - When issue_cnt reaches len after an issue, go to DRAIN.
- DRAIN: no reads. Go to IDLE in the cycle `done` pulses.
- Return path:
  - Read data arriving in a non-stall cycle is registered onto `out_val`/`out_tag_id` with `out_valid`=1.
  - Read data arriving in a stall cycle is written into the hold register (hold_full=1).
  - First non-stall cycle with hold_full: emit the hold contents, clear hold_full. By construction no new data returns in that cycle.
- Tag for word k (emit order) = tag_base + floor(k/period), mod 2^ID_WIDTH (wraps). Implement with a sub-counter that resets at period-1 and increments the tag; period=0 means the tag stays at tag_base.
- `done` is asserted in the same cycle as `out_valid` of word len-1.
- `out_valid`=0 whenever `stall`=1 (registered from the previous cycle's decision; see Timing).
- Reset, including mid-burst: FSM to IDLE, counters and hold_full cleared, in-flight read data discarded, no `done`.
- All outputs reset to 0 except `cmd_ready`, which is 1 once in IDLE after reset is released.

## Timing
- Handshake accepted in cycle T → first `mem_rd_en` in T+1 (if unstalled) → data at T+2 → `out_valid` at T+3.
- Issue-to-output latency: 2 cycles when unstalled. Throughput: 1 word/cycle.
- A stall in cycle N:
  - blocks the read in N;
  - forces `out_valid`=0 in N+1;
  - captures the word returning in N into the hold register.
- After stall drops in cycle M: held word appears at M+1, and the word read in M appears at M+2. Order is preserved.
- `cmd_ready` returns to 1 the cycle after `done`.
- `cmd_valid` while busy is ignored (not latched).

## Structure
- Shared package `eyeriss_pkg`:
  - `seq_state_t` enum {IDLE, RUN, DRAIN};
  - default width localparams, shared with `MulticastRouter`.
- No sub-module. The skid register and tag counter stay inline; the estimated size is ~150–200 lines.

## Test plan
- Basic burst: base=0x010, len=4, tag_base=3, period=2; SRAM[a]=a → out (0x010,3), (0x011,3), (0x012,4), (0x013,4) on four consecutive cycles starting T+3; `done` with the 4th word.
- len=0 → no `mem_rd_en`, `done` pulses at T+1, `cmd_ready` high at T+2.
- One-cycle stall mid-burst (len=6): all 6 words emitted exactly once, in address order, with a single bubble.
- Wrap: base=0x3FE, len=4, tag_base=0xFF, period=1 → addresses 0x3FE, 0x3FF, 0x000, 0x001; tags 0xFF, 0x00, 0x01, 0x02.
- Reset asserted in RUN after 2 words → next cycle all outputs 0, `cmd_ready`=1, no `done`; a new command then runs cleanly.
- `cmd_valid` held high through a burst → exactly one command accepted per `done`.
